regfile_dump_unit: RTL and testbench

- Debug readout engine for the RISC-V register file: the reader on the regfile's read-port interface.
- On request, walks a register-address range, drives the regfile read address, and captures the combinational read data.
- Streams each {address, data} pair out over a valid/ready interface to the debug/trace path.
- Sits beside the core, using a dedicated third regfile read port. It never writes the regfile.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_dump_unit.sv | 110 +++++++++++
 tb/tb_regfile_dump_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes used by the regfile dump unit.
// Holds the dump FSM state encoding.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        FIN
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit.sv
// Debug readout engine: walks a regfile address range on a spare read port
// and streams {addr, data} words out; REGDUMP_SKIP_X0_EN suppresses x0.
module regfile_dump_unit #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    import regfile_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [ADDR_WIDTH-1:0] next_addr;

    // The read port is only steered while capturing; otherwise it parks at x0.
    assign rf_read_addr = (state == READ) ? cur : '0;
    assign next_addr    = (cur == TOP_ADDR) ? '0 : cur + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            end_addr  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur      <= first_addr;
                        end_addr <= last_addr;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef REGDUMP_SKIP_X0_EN
                    else if (cur == '0 && cur != end_addr) begin
                        cur <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end else if (cur == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
`endif
                    else begin
                        out_addr  <= cur;
                        out_data  <= (cur == '0) ? '0 : rf_read_data;
                        out_last  <= (cur == end_addr);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            cur   <= next_addr;
                            state <= READ;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Scoreboard bench for regfile_dump_unit: directed dumps, backpressure,
// wrap, abort and async reset; REGDUMP_SKIP_X0_EN variants included.
module tb_regfile_dump_unit;

    import regfile_pkg::*;

    typedef struct packed {
        reg_addr_t a;
        reg_word_t d;
        logic      l;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      start = 1'b0;
    logic      abort = 1'b0;
    logic      out_ready = 1'b0;
    reg_addr_t first_addr = '0;
    reg_addr_t last_addr = '0;
    reg_addr_t rf_read_addr;
    reg_word_t rf_read_data;
    logic      out_valid;
    reg_addr_t out_addr;
    reg_word_t out_data;
    logic      out_last;
    logic      busy;
    logic      done;

    reg_word_t regs [NUM_REGS];
    exp_t      q [$];
    int        total = 0;
    int        bad = 0;
    int        done_cnt = 0;
    logic      pending_done = 1'b0;
    logic      allow_free_done = 1'b0;

    assign rf_read_data = regs[rf_read_addr];

    always #5 clk = ~clk;

    regfile_dump_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .first_addr   (first_addr),
        .last_addr    (last_addr),
        .abort        (abort),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input logic [31:0] d, input logic l);
        exp_t e;
        e.a = reg_addr_t'(a);
        e.d = d;
        e.l = l;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every sampled handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pending_done) begin
                    check("done_after_last", {31'd0, done}, 32'd1);
                    pending_done = 1'b0;
                end else if (done && !allow_free_done) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: addr=%0d data=%0h", out_addr, out_data);
                    end else begin
                        e = q.pop_front();
                        check("word_addr", {27'd0, out_addr}, {27'd0, e.a});
                        check("word_data", out_data, e.d);
                        check("word_last", {31'd0, out_last}, {31'd0, e.l});
                        if (out_last && !abort) pending_done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input int f, input int l);
        @(posedge clk);
        #1;
        first_addr = reg_addr_t'(f);
        last_addr  = reg_addr_t'(l);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_regs();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(i * 32'h11);
    endtask

    initial begin
        int n;
        load_regs();
        fork
            monitor();
        join_none

        // Reset values
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rf_addr", {27'd0, rf_read_addr}, 32'd0);
        check("rst_out_addr", {27'd0, out_addr}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full dump 0..31
        out_ready = 1'b1;
`ifdef REGDUMP_SKIP_X0_EN
        for (int i = 1; i < 32; i++) push(i, 32'(i * 32'h11), i == 31);
`else
        for (int i = 0; i < 32; i++) push(i, 32'(i * 32'h11), i == 31);
`endif
        pulse_start(0, 31);
        wait_idle(200);
        check("full_queue_empty", 32'(q.size()), 32'd0);
        check("full_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure on a single word, plus a start while busy
        regs[5] = 32'hDEADBEEF;
        out_ready = 1'b0;
        push(5, 32'hDEADBEEF, 1'b1);
        pulse_start(5, 5);
        check("lat_read_valid", {31'd0, out_valid}, 32'd0);
        check("lat_read_busy", {31'd0, busy}, 32'd1);
        check("lat_read_rfaddr", {27'd0, rf_read_addr}, 32'd5);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'hDEADBEEF);
            check("bp_addr", {27'd0, out_addr}, 32'd5);
            check("bp_last", {31'd0, out_last}, 32'd1);
            if (k == 1) begin
                first_addr = 5'd9;
                last_addr  = 5'd9;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle(20);
        check("bp_queue_empty", 32'(q.size()), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'd2);

        // Wrap 30 -> 1 with a poisoned x0 entry
        regs[0]  = 32'hFFFFFFFF;
        regs[30] = 32'h1E1E1E1E;
        regs[31] = 32'h1F1F1F1F;
        regs[1]  = 32'h01010101;
        push(30, 32'h1E1E1E1E, 1'b0);
        push(31, 32'h1F1F1F1F, 1'b0);
`ifndef REGDUMP_SKIP_X0_EN
        push(0, 32'h0, 1'b0);
`endif
        push(1, 32'h01010101, 1'b1);
        pulse_start(30, 1);
        wait_idle(50);
        check("wrap_queue_empty", 32'(q.size()), 32'd0);
        check("wrap_done_cnt", 32'(done_cnt), 32'd3);

        // Abort on the handshake of word 3
        load_regs();
`ifndef REGDUMP_SKIP_X0_EN
        push(0, 32'h0, 1'b0);
`endif
        for (int i = 1; i < 4; i++) push(i, 32'(i * 32'h11), 1'b0);
        pulse_start(0, 31);
        n = 0;
        while (!(out_valid && out_addr == 5'd3) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach3", {27'd0, out_addr}, 32'd3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_queue_empty", 32'(q.size()), 32'd0);
        check("abort_done_cnt", 32'(done_cnt), 32'd3);
        regs[7] = 32'h77;
        push(7, 32'h77, 1'b1);
        pulse_start(7, 7);
        wait_idle(20);
        check("restart_done_cnt", 32'(done_cnt), 32'd4);

        // Async reset mid-SEND
        out_ready = 1'b0;
        regs[4] = 32'h44;
        pulse_start(4, 31);
        @(posedge clk);
        #1;
        check("ar_valid_before", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_rfaddr", {27'd0, rf_read_addr}, 32'd0);
        check("ar_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_idle_busy", {31'd0, busy}, 32'd0);
        check("ar_idle_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

`ifdef REGDUMP_SKIP_X0_EN
        push(1, 32'h11, 1'b0);
        push(2, 32'h22, 1'b1);
        pulse_start(0, 2);
        wait_idle(20);
        check("skip02_queue_empty", 32'(q.size()), 32'd0);
        check("skip02_done_cnt", 32'(done_cnt), 32'd5);
        allow_free_done = 1'b1;
        pulse_start(0, 0);
        @(posedge clk);
        #1;
        check("skip00_done", {31'd0, done}, 32'd1);
        check("skip00_valid", {31'd0, out_valid}, 32'd0);
        wait_idle(10);
        allow_free_done = 1'b0;
        check("skip00_done_cnt", 32'(done_cnt), 32'd6);
`endif

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
